// File: rtl/masked_sbox_scheduler_pkg.sv
// masked_sbox_scheduler_pkg
// Shared constants for the masked S-box scheduler slice: response source
// encoding, FSM state encodings and the round-robin pick helper.
// No ports (package).
package masked_sbox_scheduler_pkg;

    typedef logic [1:0] state_t;

    localparam logic SRC_ST = 1'b0;
    localparam logic SRC_KY = 1'b1;

    localparam state_t STATE_IDLE  = 2'd0;
    localparam state_t STATE_ISSUE = 2'd1;
    localparam state_t STATE_DRAIN = 2'd2;

    // prioSrc names the requester that wins when both are valid.
    function automatic logic pickSrc(input logic stValid, input logic kyValid, input logic prioSrc);
        if (stValid && kyValid) return prioSrc;
        else if (kyValid)       return SRC_KY;
        else                    return SRC_ST;
    endfunction

endpackage

// File: rtl/masked_sbox_scheduler_if.sv
// masked_sbox_scheduler_if
// Bundles every non-clock signal of the scheduler.
// Parameters: SHARES (Boolean shares per byte), TAG_W (requester tag width).
// Modports:
//   slave  - the scheduler: consumes requests, PRNG status, S-box output and
//            drain request; drives readies, S-box input, responses, status.
//   master - the surroundings (requesters, PRNG, S-box, response sink).
interface masked_sbox_scheduler_if #(
    parameter int SHARES = 2,
    parameter int TAG_W  = 4
);
    localparam int DATA_W = 8 * SHARES;

    logic              StValidxSI;
    logic              StReadyxSO;
    logic [DATA_W-1:0] StDataxDI;
    logic [TAG_W-1:0]  StTagxDI;
    logic              KyValidxSI;
    logic              KyReadyxSO;
    logic [DATA_W-1:0] KyDataxDI;
    logic [TAG_W-1:0]  KyTagxDI;
    logic              RndValidxSI;
    logic              RndReadyxSO;
    logic [DATA_W-1:0] SboxInxDO;
    logic [DATA_W-1:0] SboxOutxDI;
    logic              RspValidxSO;
    logic              RspSrcxSO;
    logic [TAG_W-1:0]  RspTagxDO;
    logic [DATA_W-1:0] RspDataxDO;
    logic              DrainReqxSI;
    logic              DrainDonexSO;
    logic              BusyxSO;

    modport slave (
        input  StValidxSI, StDataxDI, StTagxDI,
        input  KyValidxSI, KyDataxDI, KyTagxDI,
        input  RndValidxSI, SboxOutxDI, DrainReqxSI,
        output StReadyxSO, KyReadyxSO, RndReadyxSO, SboxInxDO,
        output RspValidxSO, RspSrcxSO, RspTagxDO, RspDataxDO,
        output DrainDonexSO, BusyxSO
    );

    modport master (
        output StValidxSI, StDataxDI, StTagxDI,
        output KyValidxSI, KyDataxDI, KyTagxDI,
        output RndValidxSI, SboxOutxDI, DrainReqxSI,
        input  StReadyxSO, KyReadyxSO, RndReadyxSO, SboxInxDO,
        input  RspValidxSO, RspSrcxSO, RspTagxDO, RspDataxDO,
        input  DrainDonexSO, BusyxSO
    );

endinterface

// File: rtl/masked_sbox_scheduler_sbox_tag_pipe.sv
// sbox_tag_pipe
// Valid/src/tag shift register that runs alongside the S-box so each result
// can be labelled with its requester. One stage per cycle, bubbles shift in
// as invalid with zero src/tag.
// Ports:
//   ClkxCI, RstxBI        clock, asynchronous active-low reset
//   InValidxSI/InSrcxSI/InTagxDI     entry pushed this cycle (issue strobe)
//   OutValidxSO/OutSrcxSO/OutTagxDO  last stage (response side)
//   EmptyxSO              no valid entry in any stage
module sbox_tag_pipe #(
    parameter int DEPTH = 5,
    parameter int TAG_W = 4
) (
    input  logic             ClkxCI,
    input  logic             RstxBI,
    input  logic             InValidxSI,
    input  logic             InSrcxSI,
    input  logic [TAG_W-1:0] InTagxDI,
    output logic             OutValidxSO,
    output logic             OutSrcxSO,
    output logic [TAG_W-1:0] OutTagxDO,
    output logic             EmptyxSO
);

    logic [DEPTH-1:0] validxDP;
    logic [DEPTH-1:0] srcxDP;
    logic [TAG_W-1:0] tagxDP [DEPTH];

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            validxDP <= '0;
            srcxDP   <= '0;
            for (int i = 0; i < DEPTH; i++) tagxDP[i] <= '0;
        end else begin
            validxDP  <= {validxDP[DEPTH-2:0], InValidxSI};
            srcxDP    <= {srcxDP[DEPTH-2:0], InValidxSI & InSrcxSI};
            tagxDP[0] <= InValidxSI ? InTagxDI : '0;
            for (int i = 1; i < DEPTH; i++) tagxDP[i] <= tagxDP[i-1];
        end
    end

    assign OutValidxSO = validxDP[DEPTH-1];
    assign OutSrcxSO   = srcxDP[DEPTH-1];
    assign OutTagxDO   = tagxDP[DEPTH-1];
    assign EmptyxSO    = ~|validxDP;

endmodule

// File: rtl/masked_sbox_scheduler.sv
// masked_sbox_scheduler
// Shares one pipelined d-share masked AES S-box between the state datapath
// (ST) and the key schedule (KY). Issues at most one byte per cycle, only
// when the PRNG has a fresh mask set, and returns results in issue order
// labelled with source and tag. A drain sequence empties the pipe before
// key/round changes.
// Ports:
//   ClkxCI  clock
//   RstxBI  asynchronous active-low reset
//   Bus     masked_sbox_scheduler_if.slave (request handshakes, PRNG pop,
//           S-box in/out, responses, drain request/done, busy)
// Build option: KY_PRIORITY_EN defined -> KY wins every tie, no round-robin
// pointer; undefined -> round-robin starting with ST.
//
// state | meaning
// IDLE  | nothing pending; a request moves to ISSUE, a drain request is acked next cycle
// ISSUE | grants one request per cycle while masks are available
// DRAIN | grants blocked; leaves with a DrainDone pulse once the pipe is empty
module masked_sbox_scheduler
    import masked_sbox_scheduler_pkg::*;
#(
    parameter int SHARES  = 2,
    parameter int LATENCY = 4,
    parameter int TAG_W   = 4
) (
    input logic                   ClkxCI,
    input logic                   RstxBI,
    masked_sbox_scheduler_if.slave Bus
);

    localparam int DATA_W = 8 * SHARES;

    state_t            statexDP, statexDN;
    logic              idleDonexDP;
    logic [DATA_W-1:0] sboxInxDP;
    logic              anyValidxS;
    logic              grantSrcxS;
    logic              issuexS;
    logic              pipeEmptyxS;
    logic              rspValidxS;
    logic              rspSrcxS;
    logic [TAG_W-1:0]  rspTagxS;

    assign anyValidxS = Bus.StValidxSI | Bus.KyValidxSI;
    // A drain request in the same cycle suppresses the grant.
    assign issuexS = (statexDP == STATE_ISSUE) & Bus.RndValidxSI & anyValidxS & ~Bus.DrainReqxSI;

`ifdef KY_PRIORITY_EN
    assign grantSrcxS = Bus.KyValidxSI ? SRC_KY : SRC_ST;
`else
    logic prioxDP;

    assign grantSrcxS = pickSrc(Bus.StValidxSI, Bus.KyValidxSI, prioxDP);

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI)      prioxDP <= SRC_ST;
        else if (issuexS) prioxDP <= ~grantSrcxS;
    end
`endif

    always_comb begin
        statexDN = statexDP;
        case (statexDP)
            STATE_IDLE:  if (!Bus.DrainReqxSI && anyValidxS) statexDN = STATE_ISSUE;
            STATE_ISSUE: begin
                if (Bus.DrainReqxSI)                statexDN = STATE_DRAIN;
                else if (!anyValidxS && pipeEmptyxS) statexDN = STATE_IDLE;
            end
            STATE_DRAIN: if (pipeEmptyxS) statexDN = STATE_IDLE;
            default:     statexDN = STATE_IDLE;
        endcase
    end

    // The S-box input only changes on an issue: zeroing it on bubbles would
    // create transitions that recombine shares.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            statexDP    <= STATE_IDLE;
            idleDonexDP <= 1'b0;
            sboxInxDP   <= '0;
        end else begin
            statexDP    <= statexDN;
            idleDonexDP <= (statexDP == STATE_IDLE) & Bus.DrainReqxSI;
            if (issuexS) sboxInxDP <= (grantSrcxS == SRC_KY) ? Bus.KyDataxDI : Bus.StDataxDI;
        end
    end

    // LATENCY+1 stages: one for the input register, LATENCY for the S-box.
    sbox_tag_pipe #(
        .DEPTH(LATENCY + 1),
        .TAG_W(TAG_W)
    ) uTagPipe (
        .ClkxCI      (ClkxCI),
        .RstxBI      (RstxBI),
        .InValidxSI  (issuexS),
        .InSrcxSI    (grantSrcxS),
        .InTagxDI    ((grantSrcxS == SRC_KY) ? Bus.KyTagxDI : Bus.StTagxDI),
        .OutValidxSO (rspValidxS),
        .OutSrcxSO   (rspSrcxS),
        .OutTagxDO   (rspTagxS),
        .EmptyxSO    (pipeEmptyxS)
    );

    assign Bus.StReadyxSO   = issuexS & (grantSrcxS == SRC_ST);
    assign Bus.KyReadyxSO   = issuexS & (grantSrcxS == SRC_KY);
    assign Bus.RndReadyxSO  = issuexS;
    assign Bus.SboxInxDO    = sboxInxDP;
    assign Bus.RspValidxSO  = rspValidxS;
    assign Bus.RspSrcxSO    = rspSrcxS;
    assign Bus.RspTagxDO    = rspTagxS;
    assign Bus.RspDataxDO   = Bus.SboxOutxDI;
    assign Bus.DrainDonexSO = idleDonexDP | ((statexDP == STATE_DRAIN) & pipeEmptyxS);
    assign Bus.BusyxSO      = (statexDP != STATE_IDLE) | ~pipeEmptyxS;

endmodule

// File: tb/tb_masked_sbox_scheduler.sv
// tb_masked_sbox_scheduler
// Drives masked_sbox_scheduler through its interface, models the S-box as a
// delay line, and compares every cycle against a queue-based reference.
module tb_masked_sbox_scheduler;

    localparam int SHARES  = 2;
    localparam int LATENCY = 4;
    localparam int TAG_W   = 4;
    localparam int DW      = 8 * SHARES;

    logic ClkxCI = 1'b0;
    logic RstxBI = 1'b0;
    always #5 ClkxCI = ~ClkxCI;

    masked_sbox_scheduler_if #(.SHARES(SHARES), .TAG_W(TAG_W)) busxS ();

    masked_sbox_scheduler #(.SHARES(SHARES), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
        .ClkxCI (ClkxCI),
        .RstxBI (RstxBI),
        .Bus    (busxS)
    );

    // Stand-in S-box: output is a fixed bijection of the input LATENCY cycles ago.
    function automatic logic [DW-1:0] sbFunc(input logic [DW-1:0] x);
        return {x[DW-4:0], x[DW-1:DW-3]};
    endfunction

    logic [DW-1:0] sbLine [LATENCY];
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            for (int i = 0; i < LATENCY; i++) sbLine[i] <= '0;
        end else begin
            sbLine[0] <= busxS.SboxInxDO;
            for (int i = 1; i < LATENCY; i++) sbLine[i] <= sbLine[i-1];
        end
    end
    assign busxS.SboxOutxDI = sbFunc(sbLine[LATENCY-1]);

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: mode 0 idle, 1 issuing, 2 draining; responses are
    // scheduled by due cycle in a queue.
    typedef struct {
        int             due;
        bit             src;
        logic [TAG_W-1:0] tag;
        logic [DW-1:0]  data;
    } rsp_t;

    rsp_t          mQ[$];
    int            mMode = 0;
    bit            mTieKy = 1'b0;
    bit            mIdleDone = 1'b0;
    logic [DW-1:0] mSboxIn = '0;
    bit            gSt, gKy;

    task automatic modelReset();
        mMode = 0;
        mQ.delete();
        mTieKy = 1'b0;
        mIdleDone = 1'b0;
        mSboxIn = '0;
    endtask

    task automatic stepCheck();
        bit   sv, kv, rnd, drn, empty, issue, gk, eRspV;
        rsp_t r;
        sv    = busxS.StValidxSI;
        kv    = busxS.KyValidxSI;
        rnd   = busxS.RndValidxSI;
        drn   = busxS.DrainReqxSI;
        empty = (mQ.size() == 0);
        issue = (mMode == 1) && rnd && (sv || kv) && !drn;
`ifdef KY_PRIORITY_EN
        gk = kv;
`else
        gk = kv && (!sv || mTieKy);
`endif
        eRspV = !empty && (mQ[0].due == cyc);
        chk("st_ready", busxS.StReadyxSO, issue && !gk);
        chk("ky_ready", busxS.KyReadyxSO, issue && gk);
        chk("rnd_ready", busxS.RndReadyxSO, issue);
        chk("sbox_in", busxS.SboxInxDO, mSboxIn);
        chk("drain_done", busxS.DrainDonexSO, mIdleDone || (mMode == 2 && empty));
        chk("busy", busxS.BusyxSO, (mMode != 0) || !empty);
        chk("rsp_valid", busxS.RspValidxSO, eRspV);
        if (eRspV) begin
            chk("rsp_src", busxS.RspSrcxSO, mQ[0].src);
            chk("rsp_tag", busxS.RspTagxDO, mQ[0].tag);
            chk("rsp_data", busxS.RspDataxDO, sbFunc(mQ[0].data));
            void'(mQ.pop_front());
        end
        gSt = issue && !gk;
        gKy = issue && gk;
        if (issue) begin
            r.due  = cyc + 1 + LATENCY;
            r.src  = gk;
            r.tag  = gk ? busxS.KyTagxDI : busxS.StTagxDI;
            r.data = gk ? busxS.KyDataxDI : busxS.StDataxDI;
            mQ.push_back(r);
            mSboxIn = r.data;
            mTieKy  = !gk;
        end
        mIdleDone = (mMode == 0) && drn;
        case (mMode)
            0:       if (!drn && (sv || kv)) mMode = 1;
            1:       if (drn) mMode = 2; else if (!sv && !kv && empty) mMode = 0;
            default: if (empty) mMode = 0;
        endcase
        cyc++;
    endtask

    // Requester sources: once valid, hold data/tag until granted.
    logic             stV = 1'b0, kyV = 1'b0;
    logic [DW-1:0]    stD = '0, kyD = '0;
    logic [TAG_W-1:0] stT = '0, kyT = '0;
    logic [TAG_W-1:0] stNext = 4'd1, kyNext = 4'd1;
    int               stLeft = 0, kyLeft = 0;

    task automatic drive(input bit rnd, input bit drn);
        busxS.StValidxSI  = stV;
        busxS.StDataxDI   = stD;
        busxS.StTagxDI    = stT;
        busxS.KyValidxSI  = kyV;
        busxS.KyDataxDI   = kyD;
        busxS.KyTagxDI    = kyT;
        busxS.RndValidxSI = rnd;
        busxS.DrainReqxSI = drn;
    endtask

    task automatic applyAndCheck(input bit rnd, input bit drn);
        drive(rnd, drn);
        #1;
        stepCheck();
        if (gSt) stV = 1'b0;
        if (gKy) kyV = 1'b0;
    endtask

    task automatic cycleGen(input int pSt, input int pKy, input int pRnd, input int pDrn);
        @(negedge ClkxCI);
        if (!stV && stLeft > 0 && $urandom_range(99) < pSt) begin
            stV = 1'b1; stD = DW'($urandom); stT = stNext; stNext++; stLeft--;
        end
        if (!kyV && kyLeft > 0 && $urandom_range(99) < pKy) begin
            kyV = 1'b1; kyD = DW'($urandom); kyT = kyNext; kyNext++; kyLeft--;
        end
        applyAndCheck($urandom_range(99) < pRnd, $urandom_range(99) < pDrn);
    endtask

    task automatic chkResetZero();
        chk("rst_st_ready", busxS.StReadyxSO, 0);
        chk("rst_ky_ready", busxS.KyReadyxSO, 0);
        chk("rst_rnd_ready", busxS.RndReadyxSO, 0);
        chk("rst_sbox_in", busxS.SboxInxDO, 0);
        chk("rst_rsp_valid", busxS.RspValidxSO, 0);
        chk("rst_rsp_src", busxS.RspSrcxSO, 0);
        chk("rst_rsp_tag", busxS.RspTagxDO, 0);
        chk("rst_rsp_data", busxS.RspDataxDO, 0);
        chk("rst_drain_done", busxS.DrainDonexSO, 0);
        chk("rst_busy", busxS.BusyxSO, 0);
    endtask

    // ST-only stream, tags 1,2,3: per-cycle inputs and expected outputs.
    typedef struct {
        bit               stV;
        logic [TAG_W-1:0] stT;
        bit               rnd;
        bit               eStR;
        bit               eRspV;
        logic [TAG_W-1:0] eTag;
        bit               eBusy;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    int ps, pk;

    initial begin
        vecs[0]  = '{1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[1]  = '{1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1};
        vecs[2]  = '{1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1};
        vecs[3]  = '{1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1};
        vecs[4]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1};
        vecs[5]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1};
        vecs[6]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1};
        vecs[7]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd2, 1'b1};
        vecs[8]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1};
        vecs[9]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1};
        vecs[10] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};

        drive(1'b0, 1'b0);
        repeat (3) @(negedge ClkxCI);
        #1 chkResetZero();
        @(negedge ClkxCI);
        RstxBI = 1'b1;

        // 1: ST only, tags 1,2,3 back to back
        for (int i = 0; i < NVEC; i++) begin
            @(negedge ClkxCI);
            stV = vecs[i].stV;
            stT = vecs[i].stT;
            stD = {(DW/TAG_W){vecs[i].stT}};
            applyAndCheck(vecs[i].rnd, 1'b0);
            chk("vec_st_ready", busxS.StReadyxSO, vecs[i].eStR);
            chk("vec_rsp_valid", busxS.RspValidxSO, vecs[i].eRspV);
            chk("vec_busy", busxS.BusyxSO, vecs[i].eBusy);
            if (vecs[i].eRspV) chk("vec_rsp_tag", busxS.RspTagxDO, vecs[i].eTag);
        end
        stV = 1'b0;

        // 2: both requesters continuously valid
        stLeft = 8; kyLeft = 8;
        repeat (24) cycleGen(100, 100, 100, 0);

        // 3: KY stream with one cycle without fresh masks
        kyLeft = 6;
        repeat (3) cycleGen(0, 100, 100, 0);
        cycleGen(0, 100, 0, 0);
        repeat (14) cycleGen(0, 100, 100, 0);

        // 4: drain with three items in flight, KY arriving during the drain
        stLeft = 3;
        repeat (4) cycleGen(100, 0, 100, 0);
        kyLeft = 1;
        cycleGen(0, 100, 100, 100);
        repeat (14) cycleGen(0, 0, 100, 0);

        // 5: drain in the same cycle as a pending grant
        stLeft = 2;
        repeat (2) cycleGen(100, 0, 100, 0);
        cycleGen(100, 0, 100, 100);
        repeat (14) cycleGen(0, 0, 100, 0);

        // drain request while idle
        cycleGen(0, 0, 100, 100);
        repeat (3) cycleGen(0, 0, 100, 0);

        // 6: reset with two items in flight
        stLeft = 4;
        repeat (3) cycleGen(100, 0, 100, 0);
        @(negedge ClkxCI);
        #2 RstxBI = 1'b0;
        #1 chkResetZero();
        modelReset();
        stV = 1'b0; kyV = 1'b0; stLeft = 0; kyLeft = 0;
        drive(1'b0, 1'b0);
        repeat (2) @(negedge ClkxCI);
        RstxBI = 1'b1;
        repeat (12) cycleGen(0, 0, 100, 0);

        // randomized traffic
        stLeft = 1 << 30; kyLeft = 1 << 30;
        for (int blk = 0; blk < 30; blk++) begin
            ps = $urandom_range(100);
            pk = $urandom_range(100);
            repeat (100) cycleGen(ps, pk, 70, 2);
        end
        stLeft = 0; kyLeft = 0;
        repeat (20) cycleGen(0, 0, 100, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/masked_sbox_scheduler.md
Name: masked_sbox_scheduler

Overview:
Arbitration and sequencing controller for one pipelined, d-share masked AES S-box shared by two requesters: the state datapath (ST) and the key schedule (KY).
- Accepts shared bytes through valid/ready handshakes and issues at most one byte per cycle into the S-box.
- Tracks source and tag through a shift pipe matched to the S-box latency and returns results in order.
- Gates each issue on fresh-randomness availability and supports a drain sequence before key/round changes.

Parameters:
SHARES, 2, number of Boolean shares per byte (>=2)
LATENCY, 4, S-box cycles from registered input change to valid output (>=1)
TAG_W, 4, requester tag width

Ports:
ClkxCI  in  1  clock
RstxBI  in  1  asynchronous active-low reset
StValidxSI  in  1  ST request valid
StReadyxSO  out  1  ST request accepted this cycle
StDataxDI  in  8*SHARES  ST shared byte
StTagxDI  in  TAG_W  ST tag
KyValidxSI  in  1  KY request valid
KyReadyxSO  out  1  KY request accepted this cycle
KyDataxDI  in  8*SHARES  KY shared byte
KyTagxDI  in  TAG_W  KY tag
RndValidxSI  in  1  PRNG has a fresh mask set available
RndReadyxSO  out  1  pop mask set (equals issue strobe)
SboxInxDO  out  8*SHARES  registered S-box input
SboxOutxDI  in  8*SHARES  S-box output
RspValidxSO  out  1  response valid (no backpressure)
RspSrcxSO  out  1  0=ST, 1=KY
RspTagxDO  out  TAG_W  response tag
RspDataxDO  out  8*SHARES  equals SboxOutxDI
DrainReqxSI  in  1  request drain
DrainDonexSO  out  1  one-cycle pulse when the drain completes
BusyxSO  out  1  IDLE state left or any item in flight

Behaviour:
- Reset: FSM=IDLE; valid/src/tag pipe cleared; SboxInxDO=0; every output 0; round-robin pointer = ST.
- FSM IDLE -> ISSUE on the first request. ISSUE -> DRAIN when DrainReqxSI=1. DRAIN -> IDLE when the in-flight pipe is empty, with DrainDonexSO pulsed in that transition cycle.
- ISSUE -> IDLE when no request is pending and the pipe is empty.
- DrainReqxSI in IDLE: pulse DrainDonexSO on the next cycle.
- Issue condition: state ISSUE, RndValidxSI=1, and at least one valid requester. Exactly one Ready is high on issue; RndReadyxSO=1 in the same cycle.
- No issue in DRAIN or IDLE. Requests that arrive in IDLE move the FSM to ISSUE; the first grant is possible on the following cycle.
- Arbitration (default): round-robin. If both requesters are valid, grant the one not granted last. A lone valid requester is always granted. The pointer updates only on a grant.
- Ready is combinational from valids, state and RndValidxSI. A requester must hold valid/data/tag until it is accepted.
- On a grant at cycle t:
  - SboxInxDO <= granted data at t+1.
  - SboxInxDO holds its value on non-issue cycles. It is never zeroed or changed on bubbles, to avoid share recombination transitions.
- Valid/src/tag pipe has LATENCY+1 stages; bubbles shift in as invalid.
- Response: RspValidxSO=1 exactly at cycle t+1+LATENCY, with the src/tag of the grant. Responses are strictly in order.
- No RNG (RndValidxSI=0): no grant, bubble inserted, in-flight items still complete.
- DrainReqxSI in the same cycle as a grant: the grant is suppressed and the FSM enters DRAIN.
- BusyxSO = (state != IDLE) OR any pipe stage valid.
- Asynchronous reset mid-operation: the pipe is cleared, no responses are produced for lost items, and no DrainDonexSO is issued.

Optional Feature:
KY_PRIORITY_EN:
- Defined: fixed priority. KY wins whenever both requesters are valid; the round-robin pointer is removed.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package: src encoding constants (SRC_ST=0, SRC_KY=1) and FSM state encodings (IDLE=2'd0, ISSUE=2'd1, DRAIN=2'd2).
- One natural sub-module, sbox_tag_pipe: valid/src/tag shift register of depth LATENCY+1, exposing an empty flag.

Test Plan:
1. ST only; RndValidxSI=1; ST sends tags 1,2,3 on consecutive cycles after the FSM enters ISSUE. Required: responses on 3 consecutive cycles, each LATENCY+1=5 cycles after its grant, src=0, tags 1,2,3.
2. ST and KY valid continuously. Required: grants alternate ST,KY,ST,KY; RspSrcxSO alternates from the first response; with KY_PRIORITY_EN, KY is granted every cycle and StReadyxSO=0.
3. RndValidxSI toggles 1,0,1 during a KY stream. Required: no grant and SboxInxDO unchanged in the 0 cycle; the bubble appears as RspValidxSO=0 five cycles later.
4. DrainReqxSI raised with 3 items in flight. Required: Ready=0 from that cycle; the 3 responses complete; DrainDonexSO pulses once when the pipe is empty; FSM returns to IDLE and BusyxSO=0 the next cycle.
5. DrainReqxSI in the same cycle as a pending grant. Required: the grant is suppressed, the requester keeps valid, and it is issued only after IDLE->ISSUE.
6. RstxBI asserted with 2 items in flight. Required: all outputs immediately 0 and no responses after release.
